mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have inputs mem_op[5:0], mem_result[31:0] (effective address or ALU result), mem_busB[31:0] (store data), mem_memwr, mem_memtoreg[1:0], mem_rw[4:0], mem_regWr, all from the EX/MEM register.
REQ-004 SHALL have output mem_stall, 1 bit: freezes EX/MEM and upstream stages while high.
REQ-005 SHALL have outputs dm_req, dm_we, dm_addr[31:0], dm_be[3:0], dm_wdata[31:0], and inputs dm_rdata[31:0], dm_ack, forming the data-memory port.
REQ-006 SHALL have registered outputs wb_data[31:0], wb_rw[4:0], wb_regWr, wb_memtoreg[1:0] feeding writeback.
REQ-007 SHALL have registered outputs exc_adel, exc_ades, exc_bus (1-cycle pulses) and exc_badvaddr[31:0] for cp0.

Function
REQ-008 SHALL decode opcodes LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; access = load (mem_memtoreg==01 and opcode is a load) or store (mem_memwr==1 and opcode is a store).
REQ-009 SHALL implement FSM states IDLE and ACCESS plus a 4-bit wait counter.
REQ-010 SHALL, in IDLE with an aligned access present, drive dm_req=1 and mem_stall=1 combinationally, and move to ACCESS at the next edge.
REQ-011 SHALL ignore dm_ack in IDLE; minimum access latency is 2 cycles.
REQ-012 SHALL keep dm_req=1 and mem_stall=1 in ACCESS until dm_ack=1.
REQ-013 SHALL, in the ACCESS cycle where dm_ack=1, drop mem_stall combinationally, load the wb_* registers at that edge, and return to IDLE.
REQ-014 SHALL drive dm_addr = {mem_result[31:2],2'b00} and dm_we = store.
REQ-015 SHALL set store byte enables: SB dm_be = 4'b0001<<addr[1:0], dm_wdata = {4{busB[7:0]}}; SH dm_be = addr[1]?1100:0011, dm_wdata = {2{busB[15:0]}}; SW dm_be = 1111, dm_wdata = busB (little-endian).
REQ-016 SHALL drive dm_be=1111 for loads.
REQ-017 SHALL extract load data from lane addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
REQ-018 SHALL flag misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-019 SHALL, on misalignment, issue no request and keep mem_stall=0; at the next edge it SHALL pulse exc_adel (load) or exc_ades (store), load exc_badvaddr = mem_result, and set wb_regWr=0.
REQ-020 SHALL, for a non-memory instruction, capture wb_data = mem_result, wb_rw, wb_regWr and wb_memtoreg every edge with no stall.
REQ-021 SHALL, on a completed load, set wb_data to the extracted value; on a completed store, wb_regWr=0.
REQ-022 SHALL capture wb_regWr=0 (bubble) on every edge while mem_stall=1, so writeback never sees a duplicate.
REQ-023 SHALL run the wait counter as follows: cleared on entering ACCESS, +1 each ACCESS cycle without dm_ack. When it reaches 15 with no ack, dm_req SHALL drop, exc_bus SHALL pulse, exc_badvaddr = address, wb_regWr=0, mem_stall SHALL deassert that cycle, and the FSM SHALL go to IDLE.
REQ-024 SHALL give dm_ack priority when it arrives in the same cycle as counter==15 (normal completion).
REQ-025 SHALL hold each exception output high for exactly one cycle.

Reset
REQ-026 SHALL, while rst=1, immediately force state IDLE, counter 0, dm_req=0, mem_stall=0, and all wb_* and exc_* outputs to 0, independent of clk.
REQ-027 SHALL abandon an in-flight access on reset mid-ACCESS (dm_req low asynchronously) with no writeback or exception.

Verification
REQ-028 SHALL pass: LB addr 0x103, dm_rdata 0x80FF_0000, ack on 2nd cycle -> stall 2 cycles, dm_addr 0x100, wb_data 0xFFFF_FF80, wb_regWr=1.
REQ-029 SHALL pass: SH addr 0x202, busB 0x1234_ABCD -> dm_be 1100, dm_wdata 0xABCD_ABCD, dm_we=1, wb_regWr=0.
REQ-030 SHALL pass: LW addr 0x101 -> no dm_req, exc_adel pulse, exc_badvaddr 0x101, no stall.
REQ-031 SHALL pass: SW with dm_ack never asserted -> 15 stall cycles in ACCESS, then exc_bus pulse, FSM IDLE.
REQ-032 SHALL pass: rst asserted in 3rd ACCESS cycle -> dm_req and mem_stall 0 before next edge, wb_regWr 0, no exception.
REQ-033 SHALL pass: ADD result 0x55 following a load -> wb_data 0x55 one cycle after, no stall.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if
//   Groups the signals around the memory-access stage: the EX/MEM pipeline
//   register contents, the stall back to upstream stages, the data-memory
//   port, the writeback register outputs and the cp0 exception outputs.
//   slave  : seen by mem_access (pipeline and memory inputs, everything else out)
//   master : seen by the pipeline / memory model driving mem_access
interface mem_access_if;
    // EX/MEM register contents
    logic [5:0]  mem_op;
    logic [31:0] mem_result;
    logic [31:0] mem_busB;
    logic        mem_memwr;
    logic [1:0]  mem_memtoreg;
    logic [4:0]  mem_rw;
    logic        mem_regWr;
    logic        mem_stall;
    // data-memory port
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    // writeback registers
    logic [31:0] wb_data;
    logic [4:0]  wb_rw;
    logic        wb_regWr;
    logic [1:0]  wb_memtoreg;
    // cp0 exception reporting
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic [31:0] exc_badvaddr;

    modport slave (
        input  mem_op, mem_result, mem_busB, mem_memwr, mem_memtoreg, mem_rw, mem_regWr,
        input  dm_rdata, dm_ack,
        output mem_stall, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output wb_data, wb_rw, wb_regWr, wb_memtoreg,
        output exc_adel, exc_ades, exc_bus, exc_badvaddr
    );

    modport master (
        output mem_op, mem_result, mem_busB, mem_memwr, mem_memtoreg, mem_rw, mem_regWr,
        output dm_rdata, dm_ack,
        input  mem_stall, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  wb_data, wb_rw, wb_regWr, wb_memtoreg,
        input  exc_adel, exc_ades, exc_bus, exc_badvaddr
    );
endinterface

// File: rtl/mem_access.sv
// mem_access
//   MEM pipeline stage. Decodes loads/stores held in EX/MEM, runs a
//   request/acknowledge transaction on the data-memory port while stalling
//   the pipeline, aligns load data and store byte lanes, and raises
//   address-error and bus-timeout exceptions for cp0.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_access_if.slave: EX/MEM inputs, mem_stall, data-memory port,
//          registered writeback outputs, registered exception outputs
module mem_access (
    input  logic            clk,
    input  logic            rst,
    mem_access_if.slave     bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rw_q, wb_rw_d;
    logic        wb_regwr_q, wb_regwr_d;
    logic [1:0]  wb_memtoreg_q, wb_memtoreg_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;
    logic        exc_bus_q, exc_bus_d;
    logic [31:0] exc_badvaddr_q, exc_badvaddr_d;

    logic        ld_op, st_op, half_op, word_op;
    logic        is_load, is_store, is_access, misaligned;
    logic        req_c, stall_c;
    logic [1:0]  lane;
    logic [31:0] load_data;
    logic [7:0]  rd_byte [4];

    assign lane = bus.mem_result[1:0];

    // Opcode classification
    always_comb begin
        ld_op   = 1'b0;
        st_op   = 1'b0;
        half_op = 1'b0;
        word_op = 1'b0;
        case (bus.mem_op)
            OP_LB, OP_LBU: ld_op = 1'b1;
            OP_LH, OP_LHU: begin ld_op = 1'b1; half_op = 1'b1; end
            OP_LW:         begin ld_op = 1'b1; word_op = 1'b1; end
            OP_SB:         st_op = 1'b1;
            OP_SH:         begin st_op = 1'b1; half_op = 1'b1; end
            OP_SW:         begin st_op = 1'b1; word_op = 1'b1; end
            default: ;
        endcase
    end

    // An opcode only counts as an access when the control bits agree with it
    assign is_load    = (bus.mem_memtoreg == 2'b01) && ld_op;
    assign is_store   = bus.mem_memwr && st_op;
    assign is_access  = is_load || is_store;
    assign misaligned = (half_op && lane[0]) || (word_op && (lane != 2'b00));

    // Read-data byte lanes, little-endian
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = bus.dm_rdata[8*gi +: 8];
    end

    // Load extraction: byte from lane, halfword from upper/lower half
    always_comb begin
        load_data = bus.dm_rdata;
        case (bus.mem_op)
            OP_LB:  load_data = {{24{rd_byte[lane][7]}}, rd_byte[lane]};
            OP_LBU: load_data = {24'h0, rd_byte[lane]};
            OP_LH:  load_data = lane[1] ? {{16{bus.dm_rdata[31]}}, bus.dm_rdata[31:16]}
                                        : {{16{bus.dm_rdata[15]}}, bus.dm_rdata[15:0]};
            OP_LHU: load_data = lane[1] ? {16'h0, bus.dm_rdata[31:16]}
                                        : {16'h0, bus.dm_rdata[15:0]};
            default: ;
        endcase
    end

    // Store lane steering: data replicated across lanes, byte enables pick the target
    always_comb begin
        bus.dm_be    = 4'b1111;
        bus.dm_wdata = bus.mem_busB;
        if (is_store) begin
            case (bus.mem_op)
                OP_SB: begin
                    bus.dm_be    = 4'b0001 << lane;
                    bus.dm_wdata = {4{bus.mem_busB[7:0]}};
                end
                OP_SH: begin
                    bus.dm_be    = lane[1] ? 4'b1100 : 4'b0011;
                    bus.dm_wdata = {2{bus.mem_busB[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign bus.dm_addr = {bus.mem_result[31:2], 2'b00};
    assign bus.dm_we   = is_store;

    // Next state and writeback/exception capture
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        req_c          = 1'b0;
        stall_c        = 1'b0;
        wb_data_d      = bus.mem_result;
        wb_rw_d        = bus.mem_rw;
        wb_regwr_d     = bus.mem_regWr;
        wb_memtoreg_d  = bus.mem_memtoreg;
        exc_adel_d     = 1'b0;
        exc_ades_d     = 1'b0;
        exc_bus_d      = 1'b0;
        exc_badvaddr_d = exc_badvaddr_q;
        case (state_q)
            IDLE: begin
                if (is_access) begin
                    if (misaligned) begin
                        exc_adel_d     = is_load;
                        exc_ades_d     = is_store;
                        exc_badvaddr_d = bus.mem_result;
                        wb_regwr_d     = 1'b0;
                    end else begin
                        // dm_ack is deliberately not looked at here
                        req_c      = 1'b1;
                        stall_c    = 1'b1;
                        wb_regwr_d = 1'b0;
                        wait_cnt_d = 4'd0;
                        state_d    = ACCESS;
                    end
                end
            end
            ACCESS: begin
                req_c = 1'b1;
                if (bus.dm_ack) begin
                    // ack wins over a simultaneous timeout
                    state_d = IDLE;
                    if (is_load) wb_data_d  = load_data;
                    else         wb_regwr_d = 1'b0;
                end else if (wait_cnt_q == 4'd15) begin
                    req_c          = 1'b0;
                    exc_bus_d      = 1'b1;
                    exc_badvaddr_d = bus.mem_result;
                    wb_regwr_d     = 1'b0;
                    state_d        = IDLE;
                end else begin
                    stall_c    = 1'b1;
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    wb_regwr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so an access present during reset cannot leak a request
    assign bus.dm_req    = req_c & ~rst;
    assign bus.mem_stall = stall_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 4'd0;
            wb_data_q      <= 32'h0;
            wb_rw_q        <= 5'd0;
            wb_regwr_q     <= 1'b0;
            wb_memtoreg_q  <= 2'b00;
            exc_adel_q     <= 1'b0;
            exc_ades_q     <= 1'b0;
            exc_bus_q      <= 1'b0;
            exc_badvaddr_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            wb_data_q      <= wb_data_d;
            wb_rw_q        <= wb_rw_d;
            wb_regwr_q     <= wb_regwr_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            exc_adel_q     <= exc_adel_d;
            exc_ades_q     <= exc_ades_d;
            exc_bus_q      <= exc_bus_d;
            exc_badvaddr_q <= exc_badvaddr_d;
        end
    end

    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rw        = wb_rw_q;
    assign bus.wb_regWr     = wb_regwr_q;
    assign bus.wb_memtoreg  = wb_memtoreg_q;
    assign bus.exc_adel     = exc_adel_q;
    assign bus.exc_ades     = exc_ades_q;
    assign bus.exc_bus      = exc_bus_q;
    assign bus.exc_badvaddr = exc_badvaddr_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Directed and random instruction stream through mem_access with a
//   behavioural model of load/store semantics, alignment and timeout.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    mem_access_if bus();
    mem_access dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit op_load(input logic [5:0] op);
        return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    endfunction
    function automatic bit op_store(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction
    function automatic int op_size(input logic [5:0] op);
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
        return 4;
    endfunction

    // Value a load delivers: shift the addressed lane down, mask, extend
    function automatic logic [31:0] load_val(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (op_size(op))
            1: begin v = v & 32'hFF;   if (op == 6'h20 && v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            2: begin v = v & 32'hFFFF; if (op == 6'h21 && v >= 32'h8000) v = v | 32'hFFFF_0000; end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [31:0] a);
        if (!op_store(op)) return 4'hF;
        case (op_size(op))
            1: return 4'(1 << (a % 4));
            2: return (a % 4 >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] b);
        case (op_size(op))
            1: return (b & 32'hFF) * 32'h0101_0101;
            2: return (b & 32'hFFFF) * 32'h0001_0001;
            default: return b;
        endcase
    endfunction

    task automatic check_exc(input bit adel, input bit ades, input bit buserr);
        chk("exc_adel", 32'(bus.exc_adel), 32'(adel));
        chk("exc_ades", 32'(bus.exc_ades), 32'(ades));
        chk("exc_bus",  32'(bus.exc_bus),  32'(buserr));
    endtask

    // Entered and left just after a falling edge. ack_at = ACCESS cycle that
    // carries dm_ack (1 = first); values above 16 mean no ack ever.
    task automatic run_instr(input logic [5:0] op, input logic [31:0] res, input logic [31:0] b,
                             input logic memwr, input logic [1:0] mtr, input logic [4:0] rw,
                             input logic regwr, input logic [31:0] rdata, input int ack_at,
                             input bit idle_ack);
        bit ld, st, mis, done, acked;
        int k, stalls, exp_stalls;
        bus.mem_op = op;  bus.mem_result = res; bus.mem_busB = b; bus.mem_memwr = memwr;
        bus.mem_memtoreg = mtr; bus.mem_rw = rw; bus.mem_regWr = regwr;
        bus.dm_rdata = rdata; bus.dm_ack = idle_ack;
        ld  = (mtr == 2'b01) && op_load(op);
        st  = memwr && op_store(op);
        mis = (ld || st) && (res % op_size(op) != 0);
        #1;
        if (!(ld || st) || mis) begin
            chk("stall_none", 32'(bus.mem_stall), 32'd0);
            chk("req_none",   32'(bus.dm_req),    32'd0);
            @(posedge clk); @(negedge clk);
            if (!mis) begin
                chk("wb_data_alu", bus.wb_data, res);
                chk("wb_rw",       32'(bus.wb_rw), 32'(rw));
                chk("wb_regwr",    32'(bus.wb_regWr), 32'(regwr));
                chk("wb_memtoreg", 32'(bus.wb_memtoreg), 32'(mtr));
                check_exc(0, 0, 0);
            end else begin
                check_exc(ld, st, 0);
                chk("badvaddr_align", bus.exc_badvaddr, res);
                chk("wb_regwr_align", 32'(bus.wb_regWr), 32'd0);
            end
            $display("op=%h addr=%h %s", op, res, mis ? "misaligned" : "non-memory");
            return;
        end
        chk("req_idle",   32'(bus.dm_req),    32'd1);
        chk("stall_idle", 32'(bus.mem_stall), 32'd1);
        chk("dm_addr",    bus.dm_addr, res & 32'hFFFF_FFFC);
        chk("dm_we",      32'(bus.dm_we), 32'(st));
        chk("dm_be",      32'(bus.dm_be), 32'(exp_be(op, res)));
        if (st) chk("dm_wdata", bus.dm_wdata, exp_wdata(op, b));
        stalls = 1; k = 1; done = 0; acked = 0;
        @(posedge clk);
        while (!done && k <= 17) begin
            @(negedge clk);
            bus.dm_ack = (k == ack_at);
            #1;
            if (k == 1) chk("wb_bubble", 32'(bus.wb_regWr), 32'd0);
            chk("stall_access", 32'(bus.mem_stall), 32'(!(bus.dm_ack || k >= 16)));
            chk("req_access",   32'(bus.dm_req),    32'(!(k >= 16 && !bus.dm_ack)));
            if (bus.mem_stall) stalls++;
            else begin done = 1; acked = bus.dm_ack; end
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        chk("access_ends", 32'(done), 32'd1);
        exp_stalls = (ack_at >= 1 && ack_at <= 16) ? ack_at : 16;
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (ack_at >= 1 && ack_at <= 16) begin
            chk("acked", 32'(acked), 32'd1);
            check_exc(0, 0, 0);
            if (ld) begin
                chk("wb_load_data", bus.wb_data, load_val(op, res, rdata));
                chk("wb_load_rw",   32'(bus.wb_rw), 32'(rw));
                chk("wb_load_regwr", 32'(bus.wb_regWr), 32'(regwr));
            end else
                chk("wb_store_regwr", 32'(bus.wb_regWr), 32'd0);
        end else begin
            check_exc(0, 0, 1);
            chk("badvaddr_bus", bus.exc_badvaddr, res);
            chk("wb_regwr_bus", 32'(bus.wb_regWr), 32'd0);
        end
        $display("op=%h addr=%h ack_at=%0d stalls=%0d wb_data=%h", op, res, ack_at, stalls, bus.wb_data);
    endtask

    logic [5:0] mem_ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    initial begin
        bus.mem_op = 6'h23; bus.mem_result = 32'h100; bus.mem_busB = 0; bus.mem_memwr = 0;
        bus.mem_memtoreg = 2'b01; bus.mem_rw = 5'd3; bus.mem_regWr = 1;
        bus.dm_rdata = 0; bus.dm_ack = 0;
        // Reset with an aligned load present: no request may escape
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(bus.dm_req),    32'd0);
        chk("rst_stall", 32'(bus.mem_stall), 32'd0);
        chk("rst_wb_data",  bus.wb_data, 32'd0);
        chk("rst_wb_regwr", 32'(bus.wb_regWr), 32'd0);
        check_exc(0, 0, 0);
        chk("rst_badvaddr", bus.exc_badvaddr, 32'd0);
        bus.mem_op = 6'h00; bus.mem_memtoreg = 2'b00;
        rst = 1'b0;

        // LB at 0x103, ack on second ACCESS cycle
        run_instr(6'h20, 32'h103, 32'h0, 0, 2'b01, 5'd4, 1, 32'h80FF_0000, 2, 0);
        // ADD right after a load
        run_instr(6'h00, 32'h55, 32'h0, 0, 2'b00, 5'd5, 1, 32'h0, 1, 0);
        // SH at 0x202
        run_instr(6'h29, 32'h202, 32'h1234_ABCD, 1, 2'b00, 5'd0, 0, 32'h0, 1, 1);
        // LW at 0x101: address error
        run_instr(6'h23, 32'h101, 32'h0, 0, 2'b01, 5'd6, 1, 32'h0, 1, 0);
        // SW never acknowledged: bus timeout
        run_instr(6'h2B, 32'h300, 32'hDEAD_BEEF, 1, 2'b00, 5'd0, 0, 32'h0, 99, 0);
        // ack coincides with the last wait count: normal completion
        run_instr(6'h25, 32'h402, 32'h0, 0, 2'b01, 5'd7, 1, 32'hBEEF_1234, 16, 0);
        // SB to lane 3
        run_instr(6'h28, 32'h503, 32'h0000_00A5, 1, 2'b00, 5'd0, 0, 32'h0, 3, 0);

        // Reset during the third ACCESS cycle
        bus.mem_op = 6'h2B; bus.mem_result = 32'h600; bus.mem_busB = 32'h1; bus.mem_memwr = 1;
        bus.mem_memtoreg = 2'b00; bus.mem_regWr = 0; bus.dm_ack = 0;
        #1 chk("midrst_req_before", 32'(bus.dm_req), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_req",   32'(bus.dm_req),    32'd0);
        chk("midrst_stall", 32'(bus.mem_stall), 32'd0);
        chk("midrst_regwr", 32'(bus.wb_regWr),  32'd0);
        check_exc(0, 0, 0);
        $display("reset asserted mid-access at t=%0t", $time);
        bus.mem_op = 6'h00; bus.mem_memwr = 0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        run_instr(6'h00, 32'h77, 32'h0, 0, 2'b00, 5'd9, 1, 32'h0, 1, 0);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            int sel;
            logic [5:0] op;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a = $urandom;
            if (sel < 8) begin
                op = mem_ops[sel];
                if (op_load(op))
                    run_instr(op, a, $urandom, 0, 2'b01, 5'($urandom), 1'($urandom), $urandom,
                              $urandom_range(1, 18), 1'($urandom));
                else
                    run_instr(op, a, $urandom, 1, 2'b00, 5'($urandom), 0, $urandom,
                              $urandom_range(1, 18), 1'($urandom));
            end else if (sel == 8)
                run_instr(6'h00, a, $urandom, 0, 2'b00, 5'($urandom), 1'($urandom), $urandom, 1, 0);
            else // load opcode without memtoreg: not an access
                run_instr(6'h23, a, $urandom, 0, 2'b00, 5'($urandom), 1'($urandom), $urandom, 1, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
